// File: rtl/hw16_to_w32_packer_if.sv
// Halfword stream in, 32-bit RAM write port out, plus consumer/producer pointers.
// The packer uses the slave modport; the stream producer uses the master modport.
interface hw16_to_w32_packer_if #(
    parameter int unsigned WA_W  = 9,
    parameter int unsigned PTR_W = 11
);
    logic [15:0]      IN_DATA;
    logic             IN_VALID;
    logic             IN_READY;
    logic             FLUSH;
    logic [PTR_W-1:0] RD_PTR;
    logic [WA_W-1:0]  WA;
    logic [31:0]      WD;
    logic [3:0]       WEN;
    logic             WClk_En;
    logic [PTR_W-1:0] WR_PTR;
    logic             PENDING;

    modport master (
        output IN_DATA, IN_VALID, FLUSH, RD_PTR,
        input  IN_READY, WA, WD, WEN, WClk_En, WR_PTR, PENDING
    );

    modport slave (
        input  IN_DATA, IN_VALID, FLUSH, RD_PTR,
        output IN_READY, WA, WD, WEN, WClk_En, WR_PTR, PENDING
    );
endinterface

// File: rtl/hw16_to_w32_packer.sv
// Packs a 16-bit halfword stream low-then-high into 32-bit RAM writes,
// with byte-enable partial writes on flush and read-pointer back-pressure.
module hw16_to_w32_packer #(
    parameter int unsigned WA_W  = 9,
    parameter int unsigned PTR_W = 11
) (
    input  logic                   Clk,
    input  logic                   Rst,
    hw16_to_w32_packer_if.slave    bus
);
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StHeld  = 2'd1,
        StUpper = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [PTR_W-1:0] r_acc_ptr;
    logic [PTR_W-1:0] w_acc_ptr_nxt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [WA_W-1:0]  r_wa_cnt;
    logic [WA_W-1:0]  w_wa_cnt_nxt;
    logic [15:0]      r_lo_hold;
    logic [15:0]      w_lo_hold_nxt;

    logic [WA_W-1:0]  r_wa;
    logic [WA_W-1:0]  w_wa_nxt;
    logic [31:0]      r_wd;
    logic [31:0]      w_wd_nxt;
    logic [3:0]       r_wen;
    logic [3:0]       w_wen_nxt;
    logic             r_wclk_en;
    logic             w_wclk_en_nxt;

    logic [PTR_W-1:0] w_fill;
    logic             w_in_ready;
    logic             w_xfer;

    // Fill level below half the pointer range (1024 halfwords) means space is free.
    assign w_fill     = r_acc_ptr - bus.RD_PTR;
    assign w_in_ready = !Rst && !w_fill[PTR_W-1];
    assign w_xfer     = bus.IN_VALID && w_in_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_ptr_nxt = r_acc_ptr;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_wa_cnt_nxt  = r_wa_cnt;
        w_lo_hold_nxt = r_lo_hold;
        w_wa_nxt      = r_wa;
        w_wd_nxt      = r_wd;
        w_wen_nxt     = 4'b0000;
        w_wclk_en_nxt = 1'b0;

        if (w_xfer) begin
            w_acc_ptr_nxt = r_acc_ptr + PTR_W'(1);
        end

        unique case (r_state)
            StEmpty: begin
                if (w_xfer) begin
                    w_lo_hold_nxt = bus.IN_DATA;
                    w_state_nxt   = StHeld;
                end
            end
            StHeld: begin
                if (w_xfer) begin
                    w_wd_nxt      = {bus.IN_DATA, r_lo_hold};
                    w_wen_nxt     = 4'b1111;
                    w_wa_nxt      = r_wa_cnt;
                    w_wclk_en_nxt = 1'b1;
                    w_wa_cnt_nxt  = r_wa_cnt + WA_W'(1);
                    w_wr_ptr_nxt  = r_wr_ptr + PTR_W'(2);
                    w_state_nxt   = StEmpty;
                end
            end
            StUpper: begin
                if (w_xfer) begin
                    w_wd_nxt      = {bus.IN_DATA, bus.IN_DATA};
                    w_wen_nxt     = 4'b1100;
                    w_wa_nxt      = r_wa_cnt;
                    w_wclk_en_nxt = 1'b1;
                    w_wa_cnt_nxt  = r_wa_cnt + WA_W'(1);
                    w_wr_ptr_nxt  = r_wr_ptr + PTR_W'(1);
                    w_state_nxt   = StEmpty;
                end
            end
            default: begin
                w_state_nxt = StEmpty;
            end
        endcase

        // Flush only acts when a halfword is left holding, so it never collides with a write.
        if (bus.FLUSH && (w_state_nxt == StHeld)) begin
            w_wd_nxt      = {w_lo_hold_nxt, w_lo_hold_nxt};
            w_wen_nxt     = 4'b0011;
            w_wa_nxt      = r_wa_cnt;
            w_wclk_en_nxt = 1'b1;
            w_wr_ptr_nxt  = r_wr_ptr + PTR_W'(1);
            w_state_nxt   = StUpper;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= StEmpty;
            r_acc_ptr <= '0;
            r_wr_ptr  <= '0;
            r_wa_cnt  <= '0;
            r_lo_hold <= '0;
            r_wa      <= '0;
            r_wd      <= '0;
            r_wen     <= 4'b0000;
            r_wclk_en <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc_ptr <= w_acc_ptr_nxt;
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_wa_cnt  <= w_wa_cnt_nxt;
            r_lo_hold <= w_lo_hold_nxt;
            r_wa      <= w_wa_nxt;
            r_wd      <= w_wd_nxt;
            r_wen     <= w_wen_nxt;
            r_wclk_en <= w_wclk_en_nxt;
        end
    end

    assign bus.IN_READY = w_in_ready;
    assign bus.WA       = r_wa;
    assign bus.WD       = r_wd;
    assign bus.WEN      = r_wen;
    assign bus.WClk_En  = r_wclk_en;
    assign bus.WR_PTR   = r_wr_ptr;
    assign bus.PENDING  = (r_state == StHeld);
endmodule

// File: tb/tb_hw16_to_w32_packer.sv
// Directed bench for hw16_to_w32_packer: packing, flush, back-pressure/wrap and reset.
module tb_hw16_to_w32_packer;
    localparam int unsigned WA_W  = 9;
    localparam int unsigned PTR_W = 11;

    logic Clk;
    logic Rst;
    int   n_checks;
    int   n_errors;

    hw16_to_w32_packer_if #(.WA_W(WA_W), .PTR_W(PTR_W)) bus ();

    hw16_to_w32_packer #(.WA_W(WA_W), .PTR_W(PTR_W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [15:0] data, input logic flush);
        bus.IN_DATA  = data;
        bus.IN_VALID = 1'b1;
        bus.FLUSH    = flush;
        tick();
        bus.IN_VALID = 1'b0;
        bus.FLUSH    = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] wa, input logic [31:0] wd,
                                input logic [31:0] wen);
        check({tag, ".wclk_en"}, 32'(bus.WClk_En), 32'd1);
        check({tag, ".wa"}, 32'(bus.WA), wa);
        check({tag, ".wd"}, bus.WD, wd);
        check({tag, ".wen"}, 32'(bus.WEN), wen);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".wclk_en"}, 32'(bus.WClk_En), 32'd0);
        check({tag, ".wen"}, 32'(bus.WEN), 32'd0);
    endtask

    task automatic do_reset();
        bus.IN_VALID = 1'b0;
        bus.FLUSH    = 1'b0;
        bus.RD_PTR   = '0;
        Rst          = 1'b1;
        tick();
        Rst          = 1'b0;
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        Rst          = 1'b1;
        bus.IN_DATA  = '0;
        bus.IN_VALID = 1'b0;
        bus.FLUSH    = 1'b0;
        bus.RD_PTR   = '0;
        tick();
        tick();

        // Reset state
        check("rst.in_ready", 32'(bus.IN_READY), 32'd0);
        check("rst.wa", 32'(bus.WA), 32'd0);
        check("rst.wd", bus.WD, 32'd0);
        expect_idle("rst");
        check("rst.wr_ptr", 32'(bus.WR_PTR), 32'd0);
        check("rst.pending", 32'(bus.PENDING), 32'd0);
        Rst = 1'b0;
        #1;
        check("post_rst.in_ready", 32'(bus.IN_READY), 32'd1);

        // Four transfers pack into two full words
        push(16'h1111, 1'b0);
        expect_idle("p1");
        check("p1.pending", 32'(bus.PENDING), 32'd1);
        push(16'h2222, 1'b0);
        expect_write("p2", 32'd0, 32'h2222_1111, 32'hF);
        check("p2.wr_ptr", 32'(bus.WR_PTR), 32'd2);
        push(16'h3333, 1'b0);
        expect_idle("p3");
        push(16'h4444, 1'b0);
        expect_write("p4", 32'd1, 32'h4444_3333, 32'hF);
        check("p4.wr_ptr", 32'(bus.WR_PTR), 32'd4);
        check("p4.pending", 32'(bus.PENDING), 32'd0);
        tick();
        expect_idle("p4.after");

        // Transfer then a later flush: low partial, then upper half
        do_reset();
        push(16'hAAAA, 1'b0);
        check("f1.pending", 32'(bus.PENDING), 32'd1);
        bus.FLUSH = 1'b1;
        tick();
        bus.FLUSH = 1'b0;
        expect_write("f1.flush", 32'd0, 32'hAAAA_AAAA, 32'h3);
        check("f1.wr_ptr", 32'(bus.WR_PTR), 32'd1);
        check("f1.pending", 32'(bus.PENDING), 32'd0);
        push(16'hBBBB, 1'b0);
        expect_write("f1.upper", 32'd0, 32'hBBBB_BBBB, 32'hC);
        check("f1.upper.wr_ptr", 32'(bus.WR_PTR), 32'd2);
        push(16'hCCCC, 1'b0);
        push(16'hDDDD, 1'b0);
        expect_write("f1.next", 32'd1, 32'hDDDD_CCCC, 32'hF);
        check("f1.next.wr_ptr", 32'(bus.WR_PTR), 32'd4);

        // Accept+flush in EMPTY, then accept+flush in HELD
        do_reset();
        push(16'h5555, 1'b1);
        expect_write("f2.lo", 32'd0, 32'h5555_5555, 32'h3);
        check("f2.lo.wr_ptr", 32'(bus.WR_PTR), 32'd1);
        check("f2.lo.pending", 32'(bus.PENDING), 32'd0);
        push(16'h6666, 1'b0);
        expect_write("f2.hi", 32'd0, 32'h6666_6666, 32'hC);
        check("f2.hi.wr_ptr", 32'(bus.WR_PTR), 32'd2);
        push(16'h7777, 1'b0);
        expect_idle("f2.held");
        push(16'h8888, 1'b1);
        expect_write("f2.full", 32'd1, 32'h8888_7777, 32'hF);
        check("f2.full.wr_ptr", 32'(bus.WR_PTR), 32'd4);
        tick();
        expect_idle("f2.no_partial");
        check("f2.pending", 32'(bus.PENDING), 32'd0);

        // Fill to 1024 with RD_PTR=0, then wrap WA after releasing space
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            push(16'(i), 1'b0);
        end
        expect_write("full.last", 32'd511, 32'h03FF_03FE, 32'hF);
        check("full.wr_ptr", 32'(bus.WR_PTR), 32'd1024);
        check("full.in_ready", 32'(bus.IN_READY), 32'd0);
        bus.IN_DATA  = 16'hDEAD;
        bus.IN_VALID = 1'b1;
        tick();
        tick();
        bus.IN_VALID = 1'b0;
        expect_idle("full.stall");
        check("full.stall.pending", 32'(bus.PENDING), 32'd0);
        check("full.stall.wr_ptr", 32'(bus.WR_PTR), 32'd1024);
        bus.RD_PTR = 11'd2;
        #1;
        check("wrap.in_ready", 32'(bus.IN_READY), 32'd1);
        push(16'hA0A0, 1'b0);
        expect_idle("wrap.lo");
        push(16'hB0B0, 1'b0);
        expect_write("wrap.word", 32'd0, 32'hB0B0_A0A0, 32'hF);
        check("wrap.wr_ptr", 32'(bus.WR_PTR), 32'd1026);
        check("wrap.in_ready.full", 32'(bus.IN_READY), 32'd0);

        // Reset while a halfword is pending
        do_reset();
        push(16'h1234, 1'b0);
        check("mrst.pending", 32'(bus.PENDING), 32'd1);
        bus.IN_DATA  = 16'h5678;
        bus.IN_VALID = 1'b1;
        Rst          = 1'b1;
        tick();
        expect_idle("mrst");
        check("mrst.pending0", 32'(bus.PENDING), 32'd0);
        check("mrst.wr_ptr", 32'(bus.WR_PTR), 32'd0);
        check("mrst.wa", 32'(bus.WA), 32'd0);
        check("mrst.wd", bus.WD, 32'd0);
        check("mrst.in_ready", 32'(bus.IN_READY), 32'd0);
        bus.IN_VALID = 1'b0;
        Rst          = 1'b0;
        #1;
        push(16'h9999, 1'b0);
        push(16'hAAAA, 1'b0);
        expect_write("mrst.after", 32'd0, 32'hAAAA_9999, 32'hF);
        check("mrst.after.wr_ptr", 32'(bus.WR_PTR), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/hw16_to_w32_packer.md
# hw16_to_w32_packer

Write-side streaming packer for a split-width RAM FIFO: accepts a 16-bit halfword stream and drives the 32-bit write port (WA/WD/WEN/WClk_En) of a 512x32-write / 1024x16-read RAM_16K_BLK configuration. Consecutive halfwords are packed low-then-high into one 32-bit word. A flush commits a lone pending halfword using byte enables. Back-pressure comes from the consumer's 16-bit read pointer. It is the producer end for an existing 16-bit RAM read side.

## Interface
- WA_W, 9, write address width (512 x 32-bit words)
- PTR_W, 11, pointer width in halfword units (10 address bits + 1 wrap bit)

- Clk  in  1  single clock; also drives the RAM WClk
- Rst  in  1  synchronous, active-high reset
- IN_DATA  in  16  halfword to store
- IN_VALID  in  1  IN_DATA valid
- IN_READY  out  1  packer can accept; transfer occurs when IN_VALID && IN_READY
- FLUSH  in  1  commit any held halfword after this cycle's transfer
- RD_PTR  in  PTR_W  consumer read pointer in halfwords, free-running modulo 2048
- WA  out  WA_W  RAM write address
- WD  out  32  RAM write data
- WEN  out  4  RAM byte write enables; bit0 = WD[7:0]
- WClk_En  out  1  one-cycle RAM write strobe
- WR_PTR  out  PTR_W  committed halfword pointer; RAM data valid below it
- PENDING  out  1  a halfword is held and not yet written

## Operation
- Registers:
  - acc_ptr: accepted halfwords, PTR_W bits
  - WR_PTR
  - wa_cnt: 9 bits
  - lo_hold: 16 bits
  - state
- State EMPTY: no held data; next halfword goes to bits 15:0.
  - On transfer: lo_hold <= IN_DATA; go to HELD.
- State HELD: lo_hold is pending.
  - On transfer: write WD={IN_DATA, lo_hold}, WEN=4'b1111, WA=wa_cnt; wa_cnt+1; WR_PTR+2; go to EMPTY.
- State UPPER: the low half of word wa_cnt is already written; next halfword goes to bits 31:16.
  - On transfer: write WD={IN_DATA, IN_DATA}, WEN=4'b1100, WA=wa_cnt; wa_cnt+1; WR_PTR+1; go to EMPTY.
- FLUSH is evaluated after the same cycle's transfer:
  - If the resulting state is HELD: write WD={lo_hold_next, lo_hold_next}, WEN=4'b0011, WA=wa_cnt; WR_PTR+1; wa_cnt unchanged; go to UPPER.
  - Otherwise FLUSH is a no-op.
  - Accept+FLUSH in EMPTY: the new halfword is written as a partial low half immediately (one write, WR_PTR+1, state UPPER).
  - Accept+FLUSH in HELD: one full-word write only; FLUSH is ignored.
- At most one RAM write per cycle by construction.
- acc_ptr increments by 1 on every transfer.
- IN_READY = !Rst && ((acc_ptr - RD_PTR) mod 2048) < 1024. This is combinational from registered acc_ptr and the RD_PTR input.
- Arithmetic:
  - All pointers wrap modulo 2048.
  - wa_cnt wraps 511 -> 0.
  - WA equals WR_PTR[9:1] at each full-word write.
- PENDING = (state == HELD).
- RD_PTR values behind WR_PTR by more than 1024 are illegal; behaviour is undefined.

## Timing
- Reset values: WA=0, WD=0, WEN=0, WClk_En=0, WR_PTR=0, PENDING=0, state=EMPTY, acc_ptr=0. IN_READY=0 while Rst=1 and 1 on the first cycle after.
- Rst mid-stream discards lo_hold and any write that would have issued that cycle; no WClk_En in the reset cycle.
- WA, WD, WEN and WClk_En are registered. The write strobe is high for exactly one cycle, the cycle after the triggering transfer or flush.
- WR_PTR updates in the same cycle as the strobe, so committed data is readable by the consumer from the following cycle (RAM write latency 1).
- WEN holds 4'b0000 whenever WClk_En=0.
- Full boundary: with acc_ptr - RD_PTR = 1024, IN_READY=0. A single RD_PTR advance re-enables IN_READY in the same cycle.
- Throughput: one halfword per cycle sustained. Full-word writes occur on every second transfer.

## Test plan
- Reset, then 4 transfers 0x1111, 0x2222, 0x3333, 0x4444 with RD_PTR=0:
  - writes WA=0 WD=0x22221111 WEN=F, then WA=1 WD=0x44443333 WEN=F
  - WR_PTR ends at 4; PENDING=0.
- Transfer 0xAAAA, then FLUSH one cycle later:
  - write WA=0 WEN=4'b0011 WD[15:0]=0xAAAA; WR_PTR=1; PENDING=0.
  - Next transfer 0xBBBB -> WA=0 WEN=4'b1100 WD[31:16]=0xBBBB; WR_PTR=2.
- Accept+FLUSH same cycle from EMPTY with 0x5555 -> single write WEN=4'b0011 at WA=0, WR_PTR=1.
  - Accept+FLUSH in HELD -> single WEN=F write, no partial write.
- Full and wrap, RD_PTR=0, stream 1030 halfwords:
  - IN_READY drops after 1024 accepted; WA wraps to 0 at write 513 attempt only after RD_PTR is raised.
  - Raise RD_PTR to 2 -> IN_READY=1 same cycle; next full word lands at WA=0, pointers at 1026 mod 2048.
- Assert Rst while PENDING=1 -> no WClk_En issued; all outputs return to reset values.
  - The next two transfers write at WA=0.
